// File: rtl/fbreader_axil_regs.sv
// AXI4-Lite register file for the FbReader frame-buffer reader.
// Holds enable/base/stride/scratch configuration, a sticky end-of-frame
// status bit, a free-running frame counter and the frame interrupt.
module fbreader_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              fb_enable,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     fb_base,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     fb_stride,
  input  logic                              frame_done,
  input  logic                              core_busy,
  output logic                              irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wrState_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rdState_e;

  wrState_e wrState_q;
  rdState_e rdState_q;

  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic          arready_q, rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] fbBase_q, fbBase_d;
  logic [DW-1:0] stride_q, stride_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic          status0_q, status0_d;
  logic [DW-1:0] frameCnt_q, frameCnt_d;
  logic          irq_q;

  logic [2:0]    wrIdx, rdIdx;
  logic          wrCommit, wrIsErr, rdIsErr;
  logic [DW-1:0] rdMux;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unusedBits;
  assign unusedBits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wrIdx    = S_AXI_AWADDR[4:2];
  assign rdIdx    = S_AXI_ARADDR[4:2];
  assign wrCommit = (wrState_q == WR_ACCEPT);
  assign wrIsErr  = (wrIdx >= 3'd5);
  assign rdIsErr  = (rdIdx >= 3'd6);

  function automatic logic [DW-1:0] applyStrobe(input logic [DW-1:0] oldVal,
                                                input logic [DW-1:0] newVal,
                                                input logic [NB-1:0] strb);
    logic [DW-1:0] result;
    result = oldVal;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) result[8*b +: 8] = newVal[8*b +: 8];
    end
    return result;
  endfunction

  // Write channel: wait for address and data together, pulse both readies for
  // one cycle (the commit cycle), then hold the response until it is taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrState_q <= WR_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wrState_q)
        WR_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wrState_q <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wrIsErr ? RESP_SLVERR : RESP_OKAY;
          wrState_q <= WR_RESP;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            wrState_q <= WR_IDLE;
          end
        end
        default: wrState_q <= WR_IDLE;
      endcase
    end
  end

  // Read data selection from the current register contents.
  always_comb begin
    rdMux = '0;
    case (rdIdx)
      3'd0:    rdMux = ctrl_q;
      3'd1:    rdMux = fbBase_q;
      3'd2:    rdMux = stride_q;
      3'd3:    rdMux = scratch_q;
      3'd4:    rdMux = {{(DW-2){1'b0}}, core_busy, status0_q};
      3'd5:    rdMux = frameCnt_q;
      default: rdMux = '0;
    endcase
  end

  // Read channel: one-cycle address accept, then data captured at the accept
  // edge (so a same-cycle write commit is not yet visible) and held until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdState_q <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rdState_q)
        RD_IDLE: begin
          if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
            rdState_q <= RD_ACCEPT;
          end
        end
        RD_ACCEPT: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rdMux;
          rresp_q   <= rdIsErr ? RESP_SLVERR : RESP_OKAY;
          rdState_q <= RD_DATA;
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            rdState_q <= RD_IDLE;
          end
        end
        default: rdState_q <= RD_IDLE;
      endcase
    end
  end

  // Register next-state: byte-strobed writes, W1C on status, and the frame
  // event applied last so a set always beats a simultaneous clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    fbBase_d   = fbBase_q;
    stride_d   = stride_q;
    scratch_d  = scratch_q;
    status0_d  = status0_q;
    frameCnt_d = frameCnt_q;
    if (wrCommit) begin
      case (wrIdx)
        3'd0: ctrl_d    = applyStrobe(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd1: fbBase_d  = applyStrobe(fbBase_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd2: stride_d  = applyStrobe(stride_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd3: scratch_d = applyStrobe(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd4: if (S_AXI_WDATA[0] && S_AXI_WSTRB[0]) status0_d = 1'b0;
        default: ;
      endcase
    end
    if (frame_done) begin
      status0_d  = 1'b1;
      frameCnt_d = frameCnt_q + 1'b1;
    end
  end

  // Register state and the registered interrupt, all cleared on reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_q     <= '0;
      fbBase_q   <= '0;
      stride_q   <= '0;
      scratch_q  <= '0;
      status0_q  <= 1'b0;
      frameCnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      fbBase_q   <= fbBase_d;
      stride_q   <= stride_d;
      scratch_q  <= scratch_d;
      status0_q  <= status0_d;
      frameCnt_q <= frameCnt_d;
      irq_q      <= status0_q & ctrl_q[1];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign fb_enable     = ctrl_q[0];
  assign fb_base       = fbBase_q;
  assign fb_stride     = stride_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_fbreader_axil_regs.sv
// Self-checking bench for fbreader_axil_regs: a table of single transactions
// plus hand-built multi-cycle sequences, with responses checked by a
// scoreboard as they appear on the B and R channels.
module tb_fbreader_axil_regs;

  localparam int TIMEOUT = 20;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        fb_enable;
  logic [31:0] fb_base;
  logic [31:0] fb_stride;
  logic        frame_done;
  logic        core_busy;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          isWrite;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        coreBusy;
    logic [31:0] expData;
    logic [1:0]  expResp;
  } vector_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rExp_t;

  logic [1:0] bExpQ[$];
  rExp_t      rExpQ[$];
  vector_t    vecs[20];

  always #5 ACLK = ~ACLK;

  fbreader_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .fb_enable(fb_enable), .fb_base(fb_base), .fb_stride(fb_stride),
    .frame_done(frame_done), .core_busy(core_busy), .irq(irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: a handshake is seen at the negedge before the edge that completes it.
  always @(negedge ACLK) begin
    logic [1:0] eResp;
    rExp_t      eRd;
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (bExpQ.size() == 0) begin
        timeoutFail("unexpected write response");
      end else begin
        eResp = bExpQ.pop_front();
        checkOutput("bresp", 32'(S_AXI_BRESP), 32'(eResp));
      end
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (rExpQ.size() == 0) begin
        timeoutFail("unexpected read response");
      end else begin
        eRd = rExpQ.pop_front();
        checkOutput("rdata", S_AXI_RDATA, eRd.data);
        checkOutput("rresp", 32'(S_AXI_RRESP), 32'(eRd.resp));
      end
    end
  end

  task automatic waitAwAccept(input string name);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < TIMEOUT) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= TIMEOUT) timeoutFail(name);
    tick();
  endtask

  task automatic waitBValid(input string name);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && n < TIMEOUT) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= TIMEOUT) timeoutFail(name);
    tick();
  endtask

  task automatic waitArAccept(input string name);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < TIMEOUT) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= TIMEOUT) timeoutFail(name);
    tick();
  endtask

  task automatic waitRValid(input string name);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_RVALID && n < TIMEOUT) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= TIMEOUT) timeoutFail(name);
    tick();
  endtask

  task automatic applyStimulus(input vector_t v);
    rExp_t e;
    core_busy = v.coreBusy;
    if (v.isWrite) begin
      bExpQ.push_back(v.expResp);
      S_AXI_AWADDR  = v.addr;
      S_AXI_WDATA   = v.data;
      S_AXI_WSTRB   = v.strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_BREADY  = 1'b1;
      waitAwAccept("write accept");
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      waitBValid("write response");
      S_AXI_BREADY  = 1'b0;
    end else begin
      e.data = v.expData;
      e.resp = v.expResp;
      rExpQ.push_back(e);
      S_AXI_ARADDR  = v.addr;
      S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY  = 1'b1;
      waitArAccept("read accept");
      S_AXI_ARVALID = 1'b0;
      waitRValid("read data");
      S_AXI_RREADY  = 1'b0;
    end
  endtask

  function automatic vector_t mkW(input logic [4:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [1:0] r);
    vector_t v;
    v.isWrite = 1'b1; v.addr = a; v.data = d; v.strb = s;
    v.coreBusy = 1'b0; v.expData = '0; v.expResp = r;
    return v;
  endfunction

  function automatic vector_t mkR(input logic [4:0] a, input logic b,
                                  input logic [31:0] d, input logic [1:0] r);
    vector_t v;
    v.isWrite = 1'b0; v.addr = a; v.data = '0; v.strb = '0;
    v.coreBusy = b; v.expData = d; v.expResp = r;
    return v;
  endfunction

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    applyStimulus(mkW(a, d, s, r));
  endtask

  task automatic doRead(input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
    applyStimulus(mkR(a, 1'b0, d, r));
  endtask

  initial begin
    vecs[0]  = mkW(5'h00, 32'h1, 4'hF, 2'b00);
    vecs[1]  = mkW(5'h04, 32'h2, 4'hF, 2'b00);
    vecs[2]  = mkW(5'h08, 32'h3, 4'hF, 2'b00);
    vecs[3]  = mkW(5'h0C, 32'h4, 4'hF, 2'b00);
    vecs[4]  = mkR(5'h00, 1'b0, 32'h1, 2'b00);
    vecs[5]  = mkR(5'h04, 1'b0, 32'h2, 2'b00);
    vecs[6]  = mkR(5'h08, 1'b0, 32'h3, 2'b00);
    vecs[7]  = mkR(5'h0C, 1'b0, 32'h4, 2'b00);
    vecs[8]  = mkW(5'h04, 32'hAABBCCDD, 4'b0101, 2'b00);
    vecs[9]  = mkR(5'h04, 1'b0, 32'h00BB00DD, 2'b00);
    vecs[10] = mkW(5'h0C, 32'hFFFFFFFF, 4'b0000, 2'b00);
    vecs[11] = mkR(5'h0E, 1'b0, 32'h4, 2'b00);
    vecs[12] = mkW(5'h14, 32'h55, 4'hF, 2'b10);
    vecs[13] = mkW(5'h18, 32'h66, 4'hF, 2'b10);
    vecs[14] = mkR(5'h1C, 1'b0, 32'h0, 2'b10);
    vecs[15] = mkR(5'h18, 1'b0, 32'h0, 2'b10);
    vecs[16] = mkR(5'h14, 1'b0, 32'h0, 2'b00);
    vecs[17] = mkR(5'h10, 1'b1, 32'h2, 2'b00);
    vecs[18] = mkW(5'h10, 32'hFFFFFFFE, 4'hF, 2'b00);
    vecs[19] = mkR(5'h10, 1'b0, 32'h0, 2'b00);

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    frame_done = 1'b0; core_busy = 1'b0;
    repeat (3) tick();

    checkOutput("reset readies", {28'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, 1'b0}, 32'h0);
    checkOutput("reset valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    checkOutput("reset resps", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
    checkOutput("reset rdata", S_AXI_RDATA, 32'h0);
    checkOutput("reset irq/enable", {30'b0, irq, fb_enable}, 32'h0);
    checkOutput("reset fb_base", fb_base, 32'h0);
    checkOutput("reset fb_stride", fb_stride, 32'h0);
    ARESET = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      if (i == 3) begin
        checkOutput("fb_enable after config", {31'b0, fb_enable}, 32'h1);
        checkOutput("fb_base after config", fb_base, 32'h2);
        checkOutput("fb_stride after config", fb_stride, 32'h3);
      end
    end
    core_busy = 1'b0;

    // Address leads data by three cycles; response held off for four cycles
    // while a second write is already presented.
    bExpQ.push_back(2'b00);
    bExpQ.push_back(2'b00);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checkOutput("aw alone not accepted", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
      tick();
    end
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("no accept in wvalid cycle", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
    @(negedge ACLK);
    checkOutput("aw/w ready pulse", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
    tick();
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checkOutput("bvalid held, no new accept",
                  {28'b0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY}, 32'h8);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    waitAwAccept("second write accept");
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    waitBValid("second write response");
    S_AXI_BREADY = 1'b0;
    doRead(5'h0C, 32'h12345678, 2'b00);
    doRead(5'h08, 32'h00000077, 2'b00);

    // Read accepted in the same cycle as a write commit sees the old value.
    begin
      rExp_t e;
      e.data = 32'h12345678; e.resp = 2'b00;
      rExpQ.push_back(e);
    end
    bExpQ.push_back(2'b00);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 5'h0C;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("concurrent accept", {30'b0, S_AXI_AWREADY, S_AXI_ARREADY}, 32'h3);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("concurrent responses", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    doRead(5'h0C, 32'hCAFEF00D, 2'b00);

    // Frame events, interrupt and W1C clear.
    doWrite(5'h00, 32'h3, 4'hF, 2'b00);
    for (int i = 0; i < 2; i++) begin
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      tick();
    end
    tick();
    @(negedge ACLK);
    checkOutput("irq after frames", {31'b0, irq}, 32'h1);
    tick();
    doRead(5'h14, 32'h2, 2'b00);
    doRead(5'h10, 32'h1, 2'b00);
    doWrite(5'h10, 32'h1, 4'h1, 2'b00);
    tick();
    tick();
    @(negedge ACLK);
    checkOutput("irq after clear", {31'b0, irq}, 32'h0);
    tick();
    doRead(5'h10, 32'h0, 2'b00);

    // Clear and frame event in the same commit cycle: the set wins.
    bExpQ.push_back(2'b00);
    S_AXI_AWADDR = 5'h10; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    frame_done = 1'b1;
    @(negedge ACLK);
    checkOutput("commit cycle overlaps frame_done", {31'b0, S_AXI_AWREADY}, 32'h1);
    tick();
    frame_done = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    waitBValid("clear write response");
    S_AXI_BREADY = 1'b0;
    doRead(5'h10, 32'h1, 2'b00);
    doRead(5'h14, 32'h3, 2'b00);
    @(negedge ACLK);
    checkOutput("irq after set-wins", {31'b0, irq}, 32'h1);
    tick();

    // Reset while a read response is pending and not yet taken.
    S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("pending read accepted", {31'b0, S_AXI_ARREADY}, 32'h1);
    tick();
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalid before reset", {31'b0, S_AXI_RVALID}, 32'h1);
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalid after reset", {31'b0, S_AXI_RVALID}, 32'h0);
    checkOutput("outputs after reset", {30'b0, irq, fb_enable}, 32'h0);
    checkOutput("fb_base after reset", fb_base, 32'h0);
    checkOutput("fb_stride after reset", fb_stride, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      doRead(5'(i * 4), 32'h0, 2'b00);
    end

    tick();
    checkOutput("write scoreboard drained", 32'(bExpQ.size()), 32'h0);
    checkOutput("read scoreboard drained", 32'(rExpQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
